// File: rtl/prog_loader.sv
// Boot-time program loader: streams bytes into CPU memory and holds the CPU in reset until the image is in.
// Optional checksum verification of the final byte is enabled by defining PROG_LOADER_CHKSUM_EN.
`timescale 1ns/1ps

module prog_loader #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned LOAD_BASE = 0,
    parameter int unsigned MAX_BYTES = 8192
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_chksum,
    output logic [ADDR_W:0]   byte_cnt
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   byte_cnt_q,  byte_cnt_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [7:0]         mem_data_q,  mem_data_d;
    logic               last_q,      last_d;
    logic               mem_wr_q,    mem_wr_d;
    logic               in_ready_q,  in_ready_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               cpu_rst_n_q, cpu_rst_n_d;
    logic               err_ovf_q,   err_ovf_d;
    logic               xfer_c;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0]         acc_q,       acc_d;
    logic               err_chk_q,   err_chk_d;
    logic [7:0]         sum_c;
`endif

    assign xfer_c = in_valid & in_ready_q;
`ifdef PROG_LOADER_CHKSUM_EN
    assign sum_c  = acc_q + in_data;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        last_d      = last_q;
        mem_wr_d    = 1'b0;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        done_d      = done_q;
        cpu_rst_n_d = cpu_rst_n_q;
        err_ovf_d   = err_ovf_q;
`ifdef PROG_LOADER_CHKSUM_EN
        acc_d       = acc_q;
        err_chk_d   = err_chk_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d     = S_LOAD;
                    byte_cnt_d  = '0;
                    err_ovf_d   = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    cpu_rst_n_d = 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
                    acc_d       = '0;
                    err_chk_d   = 1'b0;
`endif
                end
            end

            S_LOAD: begin
                if (xfer_c) begin
                    in_ready_d = 1'b0;
                    last_d     = in_last;
`ifdef PROG_LOADER_CHKSUM_EN
                    // The final byte is a checksum: verify it, never write it
                    if (in_last) begin
                        busy_d = 1'b0;
                        if (sum_c == 8'h00) begin
                            state_d     = S_DONE;
                            done_d      = 1'b1;
                            cpu_rst_n_d = 1'b1;
                        end else begin
                            state_d   = S_ERROR;
                            err_chk_d = 1'b1;
                        end
                    end else
`endif
                    if ((byte_cnt_q == CNT_W'(MAX_BYTES)) && !in_last) begin
                        state_d   = S_ERROR;
                        busy_d    = 1'b0;
                        err_ovf_d = 1'b1;
                    end else begin
                        state_d    = S_WRITE;
                        mem_wr_d   = 1'b1;
                        mem_data_d = in_data;
                        mem_addr_d = ADDR_W'(LOAD_BASE) + ADDR_W'(byte_cnt_q);
`ifdef PROG_LOADER_CHKSUM_EN
                        acc_d      = sum_c;
`endif
                    end
                end
            end

            S_WRITE: begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                if (last_q) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    cpu_rst_n_d = 1'b1;
                end else begin
                    state_d    = S_LOAD;
                    in_ready_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            mem_addr_q  <= ADDR_W'(LOAD_BASE);
            mem_data_q  <= '0;
            last_q      <= 1'b0;
            mem_wr_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            err_ovf_q   <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
            acc_q       <= '0;
            err_chk_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            last_q      <= last_d;
            mem_wr_q    <= mem_wr_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            err_ovf_q   <= err_ovf_d;
`ifdef PROG_LOADER_CHKSUM_EN
            acc_q       <= acc_d;
            err_chk_q   <= err_chk_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign mem_wr       = mem_wr_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_overflow = err_ovf_q;
    assign byte_cnt     = byte_cnt_q;
`ifdef PROG_LOADER_CHKSUM_EN
    assign err_chksum   = err_chk_q;
`else
    assign err_chksum   = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: random-handshake image streaming checked against a list-based loader model.
`timescale 1ns/1ps

module tb_prog_loader;

    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned LOAD_BASE = 8189;
    localparam int unsigned MAX_BYTES = 8;
`ifdef PROG_LOADER_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              sys_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_wr;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err_overflow;
    logic              err_chksum;
    logic [ADDR_W:0]   byte_cnt;

    prog_loader #(
        .ADDR_W(ADDR_W), .LOAD_BASE(LOAD_BASE), .MAX_BYTES(MAX_BYTES)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done),
        .err_overflow(err_overflow), .err_chksum(err_chksum), .byte_cnt(byte_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Memory write capture
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [7:0]        wr_data_q[$];
    int                wr_cyc_q[$];

    always @(negedge sys_clk) begin
        if (mem_wr) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
            wr_cyc_q.push_back(cyc);
        end
    end

    // Expected outcome of one image
    logic [ADDR_W-1:0] exp_addr[$];
    logic [7:0]        exp_data[$];
    bit                exp_done, exp_ovf, exp_chk;
    int                exp_cnt, exp_accept;

    task automatic model(input logic [7:0] img[$]);
        int cnt;
        int sum;
        bit last;
        cnt = 0; sum = 0;
        exp_addr.delete(); exp_data.delete();
        exp_done = 0; exp_ovf = 0; exp_chk = 0; exp_accept = 0;
        for (int i = 0; i < img.size(); i++) begin
            last = (i == img.size() - 1);
            exp_accept = i + 1;
            if (CHK && last) begin
                if (((sum + int'(img[i])) % 256) == 0) exp_done = 1;
                else exp_chk = 1;
                break;
            end
            if (cnt == int'(MAX_BYTES) && !last) begin
                exp_ovf = 1;
                break;
            end
            exp_addr.push_back(ADDR_W'((LOAD_BASE + 32'(cnt)) % (2 ** ADDR_W)));
            exp_data.push_back(img[i]);
            sum += int'(img[i]);
            cnt++;
            if (last) begin
                exp_done = 1;
                break;
            end
        end
        exp_cnt = cnt;
    endtask

    task automatic pulse_start();
        @(negedge sys_clk); start = 1'b1;
        @(negedge sys_clk); start = 1'b0;
    endtask

    // Sends the first n_send bytes of img; in_last marks img's final byte
    task automatic drive(input logic [7:0] img[$], input int n_send, input int unsigned pct, input string name);
        int idx;
        int guard;
        bit v, xfer;
        idx = 0; guard = 0;
        while (idx < n_send && guard < 2000) begin
            @(negedge sys_clk);
            guard++;
            v        = ($urandom_range(99) < pct);
            in_valid = v;
            in_data  = v ? img[idx] : 8'($urandom);
            in_last  = v ? (idx == img.size() - 1) : 1'($urandom);
            start    = ($urandom_range(9) == 0);
            xfer     = v && in_ready;
            @(posedge sys_clk);
            if (xfer) idx++;
        end
        @(negedge sys_clk);
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        checks++;
        if (idx < n_send) begin
            errors++;
            $display("FAIL %s accept: accepted %0d bytes, required %0d", name, idx, n_send);
        end
    endtask

    task automatic run_image(input logic [7:0] img[$], input int unsigned pct, input string name);
        int g;
        model(img);
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        pulse_start();
        drive(img, exp_accept, pct, name);
        g = 0;
        while (!(done || err_overflow || err_chksum) && g < 10) begin
            @(negedge sys_clk);
            g++;
        end
        checks++;
        if (done !== exp_done) begin
            errors++; $display("FAIL %s done: got %b, required %b", name, done, exp_done);
        end
        checks++;
        if (cpu_rst_n !== exp_done) begin
            errors++; $display("FAIL %s cpu_rst_n: got %b, required %b", name, cpu_rst_n, exp_done);
        end
        checks++;
        if (err_overflow !== exp_ovf) begin
            errors++; $display("FAIL %s err_overflow: got %b, required %b", name, err_overflow, exp_ovf);
        end
        checks++;
        if (err_chksum !== exp_chk) begin
            errors++; $display("FAIL %s err_chksum: got %b, required %b", name, err_chksum, exp_chk);
        end
        checks++;
        if (byte_cnt !== CNT_W'(exp_cnt)) begin
            errors++; $display("FAIL %s byte_cnt: got %0d, required %0d", name, byte_cnt, exp_cnt);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL %s idle_flags: busy=%b in_ready=%b, required 0 0", name, busy, in_ready);
        end
        checks++;
        if (wr_addr_q.size() != exp_addr.size()) begin
            errors++; $display("FAIL %s write_count: got %0d, required %0d", name, wr_addr_q.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                checks++;
                if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got %h<=%h, required %h<=%h",
                             name, i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
                end
                if (pct == 100 && i > 0) begin
                    checks++;
                    if (wr_cyc_q[i] - wr_cyc_q[i-1] != 2) begin
                        errors++;
                        $display("FAIL %s spacing[%0d]: got %0d cycles, required 2",
                                 name, i, wr_cyc_q[i] - wr_cyc_q[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; start = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            checks++;
            if ({cpu_rst_n, in_ready, mem_wr, busy, done, err_overflow, err_chksum} !== 7'b0 ||
                byte_cnt !== '0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: cpu_rst_n=%b in_ready=%b mem_wr=%b busy=%b done=%b ovf=%b chk=%b cnt=%0d, required all 0",
                         i, cpu_rst_n, in_ready, mem_wr, busy, done, err_overflow, err_chksum, byte_cnt);
            end
        end
        checks++;
        if (mem_addr !== ADDR_W'(LOAD_BASE) || mem_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mem: addr=%h data=%h, required %h 00", mem_addr, mem_data, ADDR_W'(LOAD_BASE));
        end
        in_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] img[$];
        img = '{8'hA1, 8'h02, 8'h3C};
        run_image(img, 100, "stream3");
        run_image(img, 40, "stream3_toggle");
        img = '{8'h5A};
        run_image(img, 100, "single_5a");
        img = '{8'h00};
        run_image(img, 100, "single_00");
        img = '{8'h10, 8'h20, 8'hD0};
        run_image(img, 100, "chk_good");
        img = '{8'h10, 8'h20, 8'hD1};
        run_image(img, 100, "chk_bad");
    endtask

    task automatic test_random();
        logic [7:0] img[$];
        int len, sum;
        for (int n = 0; n < 20; n++) begin
            img.delete();
            len = int'($urandom_range(1, MAX_BYTES));
            sum = 0;
            for (int i = 0; i < len; i++) begin
                img.push_back(8'($urandom));
                if (i < len - 1) sum += int'(img[i]);
            end
            if (CHK && $urandom_range(1) == 1) img[len-1] = 8'((256 - (sum % 256)) % 256);
            run_image(img, $urandom_range(30, 100), "random");
        end
    endtask

    task automatic test_overflow();
        logic [7:0] img[$];
        for (int i = 0; i < int'(MAX_BYTES) + 2; i++) img.push_back(8'($urandom));
        run_image(img, 100, "overflow");
        pulse_start();
        checks++;
        if (err_overflow !== 1'b0 || cpu_rst_n !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b cpu_rst_n=%b in_ready=%b, required 0 0 1",
                     err_overflow, cpu_rst_n, in_ready);
        end
    endtask

    task automatic test_midreset();
        logic [7:0] img[$];
        int nw;
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        pulse_start();
        drive(img, 2, 100, "midreset");
        @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_rst_n, in_ready, mem_wr, busy, done} !== 5'b0 || byte_cnt !== '0) begin
            errors++;
            $display("FAIL midreset_async: cpu_rst_n=%b in_ready=%b mem_wr=%b busy=%b done=%b cnt=%0d, required all 0",
                     cpu_rst_n, in_ready, mem_wr, busy, done, byte_cnt);
        end
        @(negedge sys_clk);
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h66;
        nw = wr_addr_q.size();
        repeat (5) @(negedge sys_clk);
        in_valid = 1'b0;
        checks++;
        if (nw != 2 || wr_addr_q.size() != 2) begin
            errors++;
            $display("FAIL midreset_writes: got %0d then %0d writes, required 2", nw, wr_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[1] !== ADDR_W'(LOAD_BASE + 1) || wr_data_q[1] !== 8'h22) begin
                errors++;
                $display("FAIL midreset_write1: got %h<=%h, required %h<=22", wr_addr_q[1], wr_data_q[1], ADDR_W'(LOAD_BASE + 1));
            end
        end
        checks++;
        if (cpu_rst_n !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: cpu_rst_n=%b in_ready=%b, required 0 0", cpu_rst_n, in_ready);
        end
        run_image(img, 100, "reload");
    endtask

    task automatic test_restart();
        logic [7:0] img[$];
        img = '{8'h01, 8'h02, 8'hFD};
        run_image(img, 100, "restart_a");
        pulse_start();
        checks++;
        if (cpu_rst_n !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1 || byte_cnt !== '0) begin
            errors++;
            $display("FAIL restart_entry: cpu_rst_n=%b done=%b in_ready=%b busy=%b cnt=%0d, required 0 0 1 1 0",
                     cpu_rst_n, done, in_ready, busy, byte_cnt);
        end
        img = '{8'h7E, 8'h82};
        run_image(img, 60, "restart_b");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_overflow();
        test_midreset();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
